iot_event_scheduler: RTL and testbench
======================================

Name: iot_event_scheduler

Overview:
- Shares the single Active IoT Devices Monitor counter between N_DEV device requesters. Each device posts an on/off event through a req/ack/nack handshake.
- The block arbitrates round-robin and issues exactly one change/on_off pulse per accepted event to the monitor.
- It keeps a per-device active bitmap and rejects redundant events (ON when already on, OFF when already off), so the monitor count never drifts.
- Sits directly upstream of the monitor: its change/on_off outputs drive the monitor's change/on_off inputs.

Parameters:
- N_DEV, 4, number of device requesters (2..16).
- CNT_W, 8, width of the active-device count mirror; must hold N_DEV.
- HOLDOFF, 1, idle cycles inserted after each issue before the next arbitration (0..15).

Ports:
- clk, in, 1, system clock, rising edge.
- rst, in, 1, asynchronous active-low reset.
- dev_req, in, N_DEV, per-device event request; held high until ack or nack.
- dev_on_off, in, N_DEV, per-device event direction: 1 = turned on, 0 = turned off. Valid while dev_req is high.
- dev_ack, out, N_DEV, one-cycle pulse: event accepted and issued.
- dev_nack, out, N_DEV, one-cycle pulse: event rejected as redundant.
- change, out, 1, one-cycle pulse to the monitor.
- on_off, out, 1, direction to the monitor. Valid when change=1, otherwise 0.
- active_map, out, N_DEV, registered on/off state of each device.
- active_cnt, out, CNT_W, number of active devices. Always equals popcount(active_map).
- busy, out, 1, high in ISSUE and WAIT states.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, active_map 0, active_cnt 0, rr_ptr 0, state IDLE. Reset mid-operation abandons the pending grant: no ack or nack is issued, and the requester re-posts after reset.
- States: IDLE, ISSUE, WAIT. All outputs are registered.
- IDLE:
  - If any dev_req is high, select the winner w as the first set bit searching upward from rr_ptr and wrapping at N_DEV-1 -> 0.
  - Latch w and dir = dev_on_off[w]; go to ISSUE.
  - dev_on_off is sampled only in this cycle.
  - If no request is pending, stay in IDLE.
- ISSUE (exactly 1 cycle; outputs are visible during this cycle):
  - Legal event (dir != active_map[w]):
    - change=1, on_off=dir, dev_ack[w]=1.
    - active_map[w] <= dir.
    - active_cnt increments when dir=1 and decrements when dir=0; it updates at the end of the cycle, in lockstep with the monitor.
  - Redundant event: change=0, on_off=0, dev_nack[w]=1, map and count unchanged.
  - In both cases rr_ptr <= (w+1) mod N_DEV.
  - Next state is WAIT if HOLDOFF>0, else IDLE.
- WAIT: count HOLDOFF cycles, then go to IDLE. Requests are not sampled in WAIT.
- Latency: request seen in IDLE at cycle T -> ack/nack and change at T+1. The next arbitration is no earlier than T+2+HOLDOFF.
- Throughput: at most one event per 2+HOLDOFF cycles.
- Requester rule: drop dev_req the cycle after seeing ack/nack. A req still high in IDLE after ack is treated as a new event, which is legal and nacks if redundant.
- Simultaneous requests: round-robin guarantees each waiting device is served within N_DEV grants.
- No saturation is needed: active_cnt ranges 0..N_DEV by construction. Arithmetic is unsigned CNT_W, with no wrap possible.
- A dev_req that deasserts without a handshake is ignored unless it was already latched in IDLE; a latched event is still issued.

Decomposition:
- Package iot_pkg holds:
  - State enum {IDLE, ISSUE, WAIT}.
  - Constants ON=1'b1 and OFF=1'b0.
  - A width helper for the HOLDOFF counter (4 bits).
- One natural sub-module: iot_rr_arbiter. Inputs: N_DEV request vector and rr_ptr. Outputs: winner index and found flag. It is combinational, and the scheduler registers its result.

Test Plan:
1. Reset, then a single device: rst low 3 cycles, release; dev_req[0]=1, on_off=1 -> dev_ack[0] and change=1, on_off=1 one cycle later; active_cnt=1, active_map=0001.
2. Redundant event: device 0 on again -> dev_nack[0]=1, change=0, active_cnt stays 1. Then device 0 off -> ack, change=1, on_off=0, active_cnt=0.
3. Round-robin fairness: all 4 devices request ON in the same cycle with HOLDOFF=1 -> acks in order 0,1,2,3 at 3-cycle spacing; active_cnt steps 1,2,3,4; change pulses equal 4.
4. Pointer wrap: rr_ptr=3 after serving device 2, with devices 1 and 3 both requesting -> device 3 granted first, then device 1.
5. Reset mid-operation: assert rst during ISSUE with device 2 granted -> outputs clear asynchronously, no ack seen, active_cnt=0. After release, a re-posted request is served normally.
6. Lockstep check: with the monitor connected, a 200-cycle random on/off stimulus keeps monitor counter_out equal to active_cnt every cycle, and the ack count minus nack-free change pulses equals 0.

Source files
------------

// File: rtl/iot_event_scheduler_pkg.sv
// iot_event_scheduler_pkg: shared types and constants for the event scheduler.
package iot_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;
  localparam logic ON = 1'b1;
  localparam logic OFF = 1'b0;
  localparam int HOLD_W = 4;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/iot_event_scheduler_if.sv
// iot_event_scheduler_if: device request/response bus plus monitor-facing outputs.
interface iot_event_scheduler_if #(parameter int N_DEV = 4, parameter int CNT_W = 8);
  logic [N_DEV-1:0] dev_req;
  logic [N_DEV-1:0] dev_on_off;
  logic [N_DEV-1:0] dev_ack;
  logic [N_DEV-1:0] dev_nack;
  logic change;
  logic on_off;
  logic [N_DEV-1:0] active_map;
  logic [CNT_W-1:0] active_cnt;
  logic busy;
  modport master (output dev_req, dev_on_off,
                  input dev_ack, dev_nack, change, on_off, active_map, active_cnt, busy);
  modport slave (input dev_req, dev_on_off,
                 output dev_ack, dev_nack, change, on_off, active_map, active_cnt, busy);
endinterface

// File: rtl/iot_event_scheduler_rr_arbiter.sv
// iot_rr_arbiter: first set request at or above ptr_i, wrapping to 0.
module iot_rr_arbiter import iot_pkg::*; #(
  parameter int N_DEV = 4,
  parameter int IW = idx_w(N_DEV)
) (
  input  logic [N_DEV-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic [IW-1:0]    win_o,
  output logic             found_o
);
  always_comb begin
    found_o = |req_i;
    win_o = '0;
    // descending scan so the smallest offset from ptr_i wins last
    for (int k = N_DEV - 1; k >= 0; k--)
      if (req_i[(int'(ptr_i) + k) % N_DEV]) win_o = IW'((int'(ptr_i) + k) % N_DEV);
  end
endmodule

// File: rtl/iot_event_scheduler.sv
// iot_event_scheduler: round-robin funnel of device on/off events into one monitor
// change/on_off stream, rejecting redundant events against a per-device bitmap.
module iot_event_scheduler import iot_pkg::*; #(
  parameter int N_DEV = 4,
  parameter int CNT_W = 8,
  parameter int HOLDOFF = 1
) (
  input logic clk,
  input logic rst_n,
  iot_event_scheduler_if.slave bus
);
  localparam int IW = idx_w(N_DEV);
  state_e state_q, state_d;
  logic [IW-1:0] win_q, win_d, rr_q, rr_d, win;
  logic found;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [N_DEV-1:0] ack_q, ack_d, nack_q, nack_d, map_q, map_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic change_q, change_d, on_off_q, on_off_d, busy_q, busy_d;
  iot_rr_arbiter #(.N_DEV(N_DEV), .IW(IW)) u_arb (
    .req_i(bus.dev_req), .ptr_i(rr_q), .win_o(win), .found_o(found)
  );
  always_comb begin
    state_d = state_q;
    win_d = win_q;
    rr_d = rr_q;
    hold_d = hold_q;
    map_d = map_q;
    cnt_d = cnt_q;
    ack_d = '0;
    nack_d = '0;
    change_d = 1'b0;
    on_off_d = 1'b0;
    case (state_q)
      IDLE: if (found) begin
        win_d = win;
        state_d = ISSUE;
        // legality is settled here so ISSUE outputs can be registered
        if (bus.dev_on_off[win] != map_q[win]) begin
          ack_d[win] = 1'b1;
          change_d = 1'b1;
          on_off_d = bus.dev_on_off[win];
        end else nack_d[win] = 1'b1;
      end
      ISSUE: begin
        if (change_q) begin
          map_d[win_q] = on_off_q;
          cnt_d = on_off_q == ON ? cnt_q + CNT_W'(1) : cnt_q - CNT_W'(1);
        end
        rr_d = win_q == IW'(N_DEV - 1) ? '0 : win_q + IW'(1);
        hold_d = HOLD_W'(HOLDOFF);
        state_d = HOLDOFF > 0 ? WAIT : IDLE;
      end
      WAIT: begin
        hold_d = hold_q - HOLD_W'(1);
        state_d = hold_q <= HOLD_W'(1) ? IDLE : WAIT;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      win_q <= '0;
      rr_q <= '0;
      hold_q <= '0;
      map_q <= '0;
      cnt_q <= '0;
      ack_q <= '0;
      nack_q <= '0;
      change_q <= 1'b0;
      on_off_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q <= win_d;
      rr_q <= rr_d;
      hold_q <= hold_d;
      map_q <= map_d;
      cnt_q <= cnt_d;
      ack_q <= ack_d;
      nack_q <= nack_d;
      change_q <= change_d;
      on_off_q <= on_off_d;
      busy_q <= busy_d;
    end
  assign bus.dev_ack = ack_q;
  assign bus.dev_nack = nack_q;
  assign bus.change = change_q;
  assign bus.on_off = on_off_q;
  assign bus.active_map = map_q;
  assign bus.active_cnt = cnt_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_iot_event_scheduler.sv
// tb_iot_event_scheduler: directed checks of arbitration, redundancy rejection, reset
// and lockstep against a behavioural monitor counter.
module tb_iot_event_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int ack_tot = 0;
  int chg_tot = 0;
  logic [7:0] mon_cnt;
  iot_event_scheduler_if #(.N_DEV(4), .CNT_W(8)) bus ();
  iot_event_scheduler #(.N_DEV(4), .CNT_W(8), .HOLDOFF(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    ack_tot <= ack_tot + $countones(bus.dev_ack);
    chg_tot <= chg_tot + int'(bus.change);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) mon_cnt <= '0;
    else if (bus.change) mon_cnt <= bus.on_off ? mon_cnt + 8'd1 : mon_cnt - 8'd1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic go(input int d, input logic dir);
    bus.dev_req[d] = 1'b1;
    bus.dev_on_off[d] = dir;
  endtask
  task automatic hs(input int d, output logic a, output logic n, output logic c,
                    output logic o, output int lat);
    a = 0; n = 0; c = 0; o = 0; lat = 99;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.dev_ack[d] || bus.dev_nack[d]) begin
        a = bus.dev_ack[d]; n = bus.dev_nack[d]; c = bus.change; o = bus.on_off; lat = i;
        bus.dev_req[d] = 1'b0;
        return;
      end
    end
    chk("handshake_timeout", 32'(d), 32'hFFFF);
  endtask
  task automatic wait_ack(output int idx);
    idx = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (|bus.dev_ack) begin
        for (int d = 0; d < 4; d++) if (bus.dev_ack[d]) idx = d;
        bus.dev_req[idx] = 1'b0;
        return;
      end
    end
    chk("ack_timeout", 32'hDEAD, 32'h0);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    bus.dev_req = '0;
    bus.dev_on_off = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  logic a, n, c, o;
  int lat, idx, prev, chg0, ack0;
  initial begin
    bus.dev_req = '0;
    bus.dev_on_off = '0;
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_ack", bus.dev_ack, 0);
    chk("rst_nack", bus.dev_nack, 0);
    chk("rst_change", bus.change, 0);
    chk("rst_map", bus.active_map, 0);
    chk("rst_cnt", bus.active_cnt, 0);
    chk("rst_busy", bus.busy, 0);
    rst_n = 1'b1;
    tick();
    // single device on
    go(0, 1'b1);
    hs(0, a, n, c, o, lat);
    chk("t1_lat", lat, 1);
    chk("t1_ack", a, 1);
    chk("t1_change", c, 1);
    chk("t1_onoff", o, 1);
    chk("t1_busy", bus.busy, 1);
    tick();
    chk("t1_cnt", bus.active_cnt, 1);
    chk("t1_map", bus.active_map, 4'b0001);
    // redundant on, then off
    go(0, 1'b1);
    hs(0, a, n, c, o, lat);
    chk("t2_nack", n, 1);
    chk("t2_noack", a, 0);
    chk("t2_nochange", c, 0);
    chk("t2_onoff0", o, 0);
    tick();
    chk("t2_cnt_keep", bus.active_cnt, 1);
    go(0, 1'b0);
    hs(0, a, n, c, o, lat);
    chk("t2_off_ack", a, 1);
    chk("t2_off_change", c, 1);
    chk("t2_off_dir", o, 0);
    tick();
    chk("t2_off_cnt", bus.active_cnt, 0);
    chk("t2_off_map", bus.active_map, 0);
    // all four at once from a fresh pointer
    do_reset();
    chg0 = chg_tot;
    bus.dev_on_off = 4'hF;
    bus.dev_req = 4'hF;
    prev = 0;
    for (int g = 0; g < 4; g++) begin
      wait_ack(idx);
      chk("t3_order", idx, g);
      if (g > 0) chk("t3_spacing", cyc - prev, 3);
      prev = cyc;
      tick();
      chk("t3_cnt_step", bus.active_cnt, g + 1);
    end
    chk("t3_changes", chg_tot - chg0, 4);
    chk("t3_map", bus.active_map, 4'hF);
    // pointer wrap: serve 2, then 1 and 3 compete
    do_reset();
    go(2, 1'b1);
    hs(2, a, n, c, o, lat);
    chk("t4_first_ack", a, 1);
    go(1, 1'b1);
    go(3, 1'b1);
    wait_ack(idx);
    chk("t4_wrap_first", idx, 3);
    wait_ack(idx);
    chk("t4_wrap_second", idx, 1);
    tick();
    chk("t4_cnt", bus.active_cnt, 3);
    chk("t4_map", bus.active_map, 4'b1110);
    // reset during ISSUE with device 2 granted
    do_reset();
    go(2, 1'b1);
    tick();
    chk("t5_issue", bus.dev_ack, 4'b0100);
    rst_n = 1'b0;
    #1;
    chk("t5_async_ack", bus.dev_ack, 0);
    chk("t5_async_change", bus.change, 0);
    chk("t5_async_busy", bus.busy, 0);
    tick();
    chk("t5_cnt", bus.active_cnt, 0);
    chk("t5_map", bus.active_map, 0);
    rst_n = 1'b1;
    hs(2, a, n, c, o, lat);
    chk("t5_repost_ack", a, 1);
    tick();
    chk("t5_repost_cnt", bus.active_cnt, 1);
    // random lockstep against the behavioural monitor
    do_reset();
    ack0 = ack_tot;
    chg0 = chg_tot;
    for (int k = 0; k < 200; k++) begin
      for (int d = 0; d < 4; d++)
        if (bus.dev_req[d] && (bus.dev_ack[d] || bus.dev_nack[d])) bus.dev_req[d] = 1'b0;
        else if (!bus.dev_req[d] && $urandom_range(0, 3) == 0) begin
          bus.dev_on_off[d] = 1'($urandom_range(0, 1));
          bus.dev_req[d] = 1'b1;
        end
      chk("t6_lockstep", bus.active_cnt, mon_cnt);
      chk("t6_popcount", bus.active_cnt, $countones(bus.active_map));
      tick();
    end
    bus.dev_req = '0;
    repeat (4) tick();
    chk("t6_ack_vs_change", ack_tot - ack0, chg_tot - chg0);
    chk("t6_final_lockstep", bus.active_cnt, mon_cnt);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
